// File: rtl/dma_mem_responder.sv
`default_nettype none
// ============================================================================
// dma_mem_responder : CE/WE memory responder with wait states, zero-fill,
//                     top-region write protection and saturating counters
// Revision: 1.0
// ============================================================================
module dma_mem_responder #(
  parameter int                ADDR_W      = 4,
  parameter int                DATA_W      = 8,
  parameter int                WAIT_STATES = 1,
  parameter bit                PROT_EN     = 1'b1,
  parameter logic [ADDR_W-1:0] PROT_BASE   = 4'hE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_we_n,
  input  logic              mem_ce_n,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_ready,
  input  logic              clear_req,
  output logic              busy,
  output logic              err,
  input  logic              err_clr,
  output logic [7:0]        rd_cnt,
  output logic [7:0]        wr_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_CLEAR  = 2'd3
  } state_t;

  localparam int                c_depth     = 2**ADDR_W;
  localparam logic [2:0]        c_wait_load = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam logic [ADDR_W-1:0] c_last_addr = {ADDR_W{1'b1}};

  state_t              r_state, w_next;
  logic [2:0]          r_wait_cnt;
  logic [ADDR_W-1:0]   r_addr_l, r_clr_addr;
  logic [DATA_W-1:0]   r_data_l;
  logic                r_we_n_l, r_clear_pend;
  logic [DATA_W-1:0]   r_mem [c_depth];

  logic                w_go;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic [DATA_W-1:0]   w_acc_data;
  logic                w_acc_we_n;
  logic                w_prot, w_wr_ok, w_wr_viol, w_rd;

  // The access is committed on the edge that enters ACCESS, so read data is
  // already on mem_data_out during the mem_ready cycle.
  always_comb begin
    w_next     = r_state;
    w_go       = 1'b0;
    w_acc_addr = r_addr_l;
    w_acc_data = r_data_l;
    w_acc_we_n = r_we_n_l;
    case (r_state)
      S_IDLE: begin
        if (!mem_ce_n) begin
          w_acc_addr = mem_addr;
          w_acc_data = mem_data_in;
          w_acc_we_n = mem_we_n;
          if (WAIT_STATES == 0) begin
            w_next = S_ACCESS;
            w_go   = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end else if (clear_req || r_clear_pend) begin
          w_next = S_CLEAR;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == 3'd0) begin
          w_next = S_ACCESS;
          w_go   = 1'b1;
        end
      end
      S_ACCESS: w_next = S_IDLE;
      S_CLEAR:  if (r_clr_addr == c_last_addr) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_prot    = PROT_EN && (w_acc_addr >= PROT_BASE);
  assign w_wr_ok   = w_go && !w_acc_we_n && !w_prot;
  assign w_wr_viol = w_go && !w_acc_we_n && w_prot;
  assign w_rd      = w_go && w_acc_we_n;
  assign mem_ready = (r_state == S_ACCESS);
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt   <= 3'd0;
      r_addr_l     <= '0;
      r_data_l     <= '0;
      r_we_n_l     <= 1'b1;
      r_clr_addr   <= '0;
      r_clear_pend <= 1'b0;
      mem_data_out <= '0;
      err          <= 1'b0;
      rd_cnt       <= 8'd0;
      wr_cnt       <= 8'd0;
    end else begin
      if (r_state == S_IDLE && !mem_ce_n) begin
        r_addr_l   <= mem_addr;
        r_data_l   <= mem_data_in;
        r_we_n_l   <= mem_we_n;
        r_wait_cnt <= c_wait_load;
      end else if (r_state == S_WAIT && r_wait_cnt != 3'd0) begin
        r_wait_cnt <= r_wait_cnt - 3'd1;
      end

      if (r_state == S_IDLE && mem_ce_n && (clear_req || r_clear_pend)) begin
        r_clr_addr   <= '0;
        r_clear_pend <= 1'b0;
      end else if (r_state == S_CLEAR && r_clr_addr != c_last_addr) begin
        r_clr_addr <= r_clr_addr + 1'b1;
      end

      // A clear that collides with an access is deferred to the next IDLE cycle.
      if (clear_req && ((r_state == S_IDLE && !mem_ce_n) ||
                        r_state == S_WAIT || r_state == S_ACCESS))
        r_clear_pend <= 1'b1;

      if (w_rd) mem_data_out <= r_mem[w_acc_addr];
      if (w_rd && rd_cnt != 8'hFF) rd_cnt <= rd_cnt + 8'd1;
      if (w_wr_ok && wr_cnt != 8'hFF) wr_cnt <= wr_cnt + 8'd1;

      if (w_wr_viol)    err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) r_mem[r_clr_addr] <= '0;
    else if (w_wr_ok)       r_mem[w_acc_addr] <= w_acc_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_mem_responder.sv
`default_nettype none
// tb_dma_mem_responder : vector table, directed multi-cycle corner cases and
// randomized accesses checked against an array/counter reference model.
module tb_dma_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WAIT_STATES=1 instance
  logic [3:0] addr1;  logic [7:0] din1;  logic we_n1, ce_n1, clr_req1, err_clr1;
  logic [7:0] dout1;  logic ready1, busy1, err1;  logic [7:0] rd1, wr1;
  // WAIT_STATES=0 instance
  logic [3:0] addr0;  logic [7:0] din0;  logic we_n0, ce_n0, clr_req0, err_clr0;
  logic [7:0] dout0;  logic ready0, busy0, err0;  logic [7:0] rd0, wr0;

  dma_mem_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_STATES(1), .PROT_EN(1'b1), .PROT_BASE(4'hE)) u_dut1 (
    .clk(clk), .rst(rst), .mem_addr(addr1), .mem_data_in(din1), .mem_we_n(we_n1),
    .mem_ce_n(ce_n1), .mem_data_out(dout1), .mem_ready(ready1), .clear_req(clr_req1),
    .busy(busy1), .err(err1), .err_clr(err_clr1), .rd_cnt(rd1), .wr_cnt(wr1));

  dma_mem_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_STATES(0), .PROT_EN(1'b1), .PROT_BASE(4'hE)) u_dut0 (
    .clk(clk), .rst(rst), .mem_addr(addr0), .mem_data_in(din0), .mem_we_n(we_n0),
    .mem_ce_n(ce_n0), .mem_data_out(dout0), .mem_ready(ready0), .clear_req(clr_req0),
    .busy(busy0), .err(err0), .err_clr(err_clr0), .rd_cnt(rd0), .wr_cnt(wr0));

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] m [16];
  int         m_rd, m_wr;
  bit         m_err;

  typedef struct {
    bit         wr;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] exp_rd;
    bit         exp_err;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request from an IDLE cycle, returns read data and cycles to mem_ready,
  // and leaves the bench in the IDLE cycle following completion.
  task automatic access(input bit d0, input bit wr, input logic [3:0] a, input logic [7:0] d,
                        output logic [7:0] rdata, output int lat);
    if (d0) begin ce_n0 = 1'b0; we_n0 = !wr; addr0 = a; din0 = d; end
    else    begin ce_n1 = 1'b0; we_n1 = !wr; addr1 = a; din1 = d; end
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(d0 ? ready0 : ready1) && lat < 64);
    rdata = d0 ? dout0 : dout1;
    if (d0) ce_n0 = 1'b1; else ce_n1 = 1'b1;
    tick();
  endtask

  task automatic op1(input bit wr, input logic [3:0] a, input logic [7:0] d, input string tag);
    logic [7:0] rd;
    logic [7:0] exp;
    int lat;
    exp = m[a];
    access(1'b0, wr, a, d, rd, lat);
    chk({tag, " latency"}, lat, 2);
    if (wr) begin
      if (a >= 4'hE) m_err = 1'b1;
      else begin
        m[a] = d;
        if (m_wr < 255) m_wr++;
      end
    end else begin
      chk({tag, " rdata"}, rd, exp);
      if (m_rd < 255) m_rd++;
    end
    chk({tag, " err"}, err1, m_err);
    chk({tag, " rd_cnt"}, rd1, m_rd);
    chk({tag, " wr_cnt"}, wr1, m_wr);
  endtask

  task automatic clear_pulse(input string tag);
    int n;
    clr_req1 = 1'b1;
    tick();
    clr_req1 = 1'b0;
    n = 0;
    while (busy1 && n < 100) begin
      n++;
      tick();
    end
    chk({tag, " busy cycles"}, n, 16);
    for (int i = 0; i < 16; i++) m[i] = 8'h00;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    int lat;

    tbl[0] = '{1'b1, 4'h3, 8'hA5, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 4'h3, 8'h00, 8'hA5, 1'b0};
    tbl[2] = '{1'b1, 4'hF, 8'h55, 8'h00, 1'b1};
    tbl[3] = '{1'b0, 4'hF, 8'h00, 8'h00, 1'b1};
    tbl[4] = '{1'b1, 4'hE, 8'h77, 8'h00, 1'b1};
    tbl[5] = '{1'b1, 4'hD, 8'h12, 8'h00, 1'b1};
    tbl[6] = '{1'b0, 4'hD, 8'h00, 8'h12, 1'b1};
    tbl[7] = '{1'b0, 4'hE, 8'h00, 8'h00, 1'b1};

    rst = 1'b1;
    addr1 = '0; din1 = '0; we_n1 = 1'b1; ce_n1 = 1'b1; clr_req1 = 1'b0; err_clr1 = 1'b0;
    addr0 = '0; din0 = '0; we_n0 = 1'b1; ce_n0 = 1'b1; clr_req0 = 1'b0; err_clr0 = 1'b0;
    m_rd = 0; m_wr = 0; m_err = 1'b0;
    tick(); tick(); tick();
    chk("reset dout",   dout1,  0);
    chk("reset ready",  ready1, 0);
    chk("reset busy",   busy1,  0);
    chk("reset err",    err1,   0);
    chk("reset rd_cnt", rd1,    0);
    chk("reset wr_cnt", wr1,    0);
    rst = 1'b0;
    tick();

    // zero wait states: completion one cycle after the request
    access(1'b1, 1'b1, 4'h1, 8'h9A, rd, lat);
    chk("ws0 write latency", lat, 1);
    access(1'b1, 1'b0, 4'h1, 8'h00, rd, lat);
    chk("ws0 read latency", lat, 1);
    chk("ws0 read data", rd, 8'h9A);
    chk("ws0 rd_cnt", rd0, 1);

    clear_pulse("init clear");

    for (int i = 0; i < 8; i++) begin
      access(1'b0, tbl[i].wr, tbl[i].a, tbl[i].d, rd, lat);
      chk($sformatf("tbl%0d latency", i), lat, 2);
      if (!tbl[i].wr) chk($sformatf("tbl%0d rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d err", i), err1, tbl[i].exp_err);
    end
    chk("tbl wr_cnt", wr1, 2);
    chk("tbl rd_cnt", rd1, 4);
    m[3] = 8'hA5; m[13] = 8'h12; m_wr = 2; m_rd = 4; m_err = 1'b1;

    err_clr1 = 1'b1;
    tick();
    err_clr1 = 1'b0;
    m_err = 1'b0;
    chk("err_clr", err1, 0);

    // fill writable region, clear, then everything reads back as zero
    for (int a = 0; a < 14; a++) op1(1'b1, 4'(a), 8'(a * 17 + 1), "fill");
    clear_pulse("fill clear");
    for (int a = 0; a < 16; a++) op1(1'b0, 4'(a), 8'h00, "post-clear");

    // clear requested together with a read: read first, then clear, then a deferred read
    op1(1'b1, 4'h2, 8'h6B, "conc setup");
    ce_n1 = 1'b0; we_n1 = 1'b1; addr1 = 4'h2; clr_req1 = 1'b1;
    tick();
    clr_req1 = 1'b0;
    tick();
    chk("conc ready", ready1, 1);
    chk("conc old data", dout1, 8'h6B);
    ce_n1 = 1'b1;
    tick();
    chk("conc idle gap busy", busy1, 0);
    tick();
    chk("conc clear busy", busy1, 1);
    ce_n1 = 1'b0; we_n1 = 1'b1; addr1 = 4'h2;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!ready1 && lat < 64);
    chk("during-clear latency", lat, 18);
    chk("during-clear data", dout1, 8'h00);
    ce_n1 = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) m[i] = 8'h00;
    m_rd = (m_rd + 2 > 255) ? 255 : m_rd + 2;
    chk("conc rd_cnt", rd1, m_rd);

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        err_clr1 = 1'b1;
        tick();
        err_clr1 = 1'b0;
        m_err = 1'b0;
        chk("rnd err_clr", err1, 0);
      end
      op1(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom), "rnd");
    end

    // reset while a write waits: no completion, array unchanged
    ce_n1 = 1'b0; we_n1 = 1'b0; addr1 = 4'h5; din1 = 8'h3C;
    tick();
    rst = 1'b1;
    #1;
    ce_n1 = 1'b1;
    chk("midrst ready",  ready1, 0);
    chk("midrst busy",   busy1,  0);
    chk("midrst err",    err1,   0);
    chk("midrst dout",   dout1,  0);
    chk("midrst rd_cnt", rd1,    0);
    chk("midrst wr_cnt", wr1,    0);
    tick();
    rst = 1'b0;
    m_rd = 0; m_wr = 0; m_err = 1'b0;
    tick();
    chk("post-rst ready", ready1, 0);
    op1(1'b0, 4'h5, 8'h00, "post-rst mem5");

    for (int k = 0; k < 300; k++) op1(1'b0, 4'($urandom_range(0, 15)), 8'h00, "sat");
    chk("rd_cnt saturated", rd1, 255);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
